// File: rtl/satprotect_mon.sv
// Registered saturating clamp with a per-cycle selectable limit, plus saturation
// flags, sticky flags, an onset counter and a sustained-saturation (railed) alarm.
module satprotect_mon #(
  parameter int Ri   = 15,
  parameter int Ro   = 14,
  parameter int SW   = 4,
  parameter int CNTW = 16,
  parameter int HOLD = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   en_i,
  input  logic [SW-1:0]          lim_i,
  input  logic                   clr_i,
  input  logic signed [Ri-1:0]   in_i,
  output logic signed [Ro-1:0]   out_o,
  output logic                   pos_sat_o,
  output logic                   neg_sat_o,
  output logic                   pos_sticky_o,
  output logic                   neg_sticky_o,
  output logic [CNTW-1:0]        sat_events_o,
  output logic                   railed_o
);

  localparam logic [SW-1:0]   LIM_MAX = SW'(Ro - 1);
  localparam logic [CNTW-1:0] CNT_MAX = '1;
  localparam logic [CNTW-1:0] HOLD_C  = CNTW'(HOLD);

  logic [SW-1:0]        lim_eff;
  logic signed [Ri-1:0] hi_lim, lo_lim;

  logic signed [Ro-1:0] out_d, out_q;
  logic                 pos_d, pos_q, neg_d, neg_q;
  logic                 pos_sticky_d, pos_sticky_q, neg_sticky_d, neg_sticky_q;
  logic [CNTW-1:0]      events_d, events_q, run_d, run_q;
  logic                 railed_d, railed_q;
  logic                 onset;

  // -2^L is the bitwise complement of 2^L-1, so one shift serves both limits
  always_comb begin
    lim_eff = (lim_i > LIM_MAX) ? LIM_MAX : lim_i;
    hi_lim  = (Ri'(1) << lim_eff) - Ri'(1);
    lo_lim  = ~hi_lim;
  end

  always_comb begin
    out_d = in_i[Ro-1:0];
    pos_d = 1'b0;
    neg_d = 1'b0;
    if (in_i > hi_lim) begin
      out_d = hi_lim[Ro-1:0];
      pos_d = 1'b1;
    end else if (in_i < lo_lim) begin
      out_d = lo_lim[Ro-1:0];
      neg_d = 1'b1;
    end
  end

  // A direction flip is a new onset, same as leaving the unsaturated range
  assign onset = en_i & ((pos_d & ~pos_q) | (neg_d & ~neg_q));

  always_comb begin
    pos_sticky_d = pos_sticky_q;
    neg_sticky_d = neg_sticky_q;
    events_d     = events_q;
    run_d        = run_q;

    if (clr_i) begin
      pos_sticky_d = 1'b0;
      neg_sticky_d = 1'b0;
      events_d     = '0;
      run_d        = '0;
    end

    if (en_i) begin
      if (pos_d) pos_sticky_d = 1'b1;
      if (neg_d) neg_sticky_d = 1'b1;

      if (onset) begin
        if (clr_i)                 events_d = CNTW'(1);
        else if (events_q != CNT_MAX) events_d = events_q + CNTW'(1);
      end

      if (!(pos_d | neg_d))         run_d = '0;
      else if (clr_i || onset)      run_d = CNTW'(1);
      else if (run_q != CNT_MAX)    run_d = run_q + CNTW'(1);
    end

    railed_d = (run_d >= HOLD_C);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_q        <= '0;
      pos_q        <= 1'b0;
      neg_q        <= 1'b0;
      pos_sticky_q <= 1'b0;
      neg_sticky_q <= 1'b0;
      events_q     <= '0;
      run_q        <= '0;
      railed_q     <= 1'b0;
    end else begin
      if (en_i) begin
        out_q <= out_d;
        pos_q <= pos_d;
        neg_q <= neg_d;
      end
      pos_sticky_q <= pos_sticky_d;
      neg_sticky_q <= neg_sticky_d;
      events_q     <= events_d;
      run_q        <= run_d;
      railed_q     <= railed_d;
    end
  end

  assign out_o        = out_q;
  assign pos_sat_o    = pos_q;
  assign neg_sat_o    = neg_q;
  assign pos_sticky_o = pos_sticky_q;
  assign neg_sticky_o = neg_sticky_q;
  assign sat_events_o = events_q;
  assign railed_o     = railed_q;

endmodule

// File: tb/tb_satprotect_mon.sv
// Directed plus randomized bench for satprotect_mon against an integer reference model.
module tb_satprotect_mon;
  localparam int HOLD    = 4;
  localparam int CNT_MAX = 65535;

  logic               clk_i = 1'b0;
  logic               rst_i;
  logic               en_i;
  logic [3:0]         lim_i;
  logic               clr_i;
  logic signed [14:0] in_i;
  logic signed [13:0] out_o;
  logic               pos_sat_o, neg_sat_o, pos_sticky_o, neg_sticky_o, railed_o;
  logic [15:0]        sat_events_o;

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_out, m_pos, m_neg, m_ps, m_ns, m_ev, m_run, m_railed;

  satprotect_mon #(.Ri(15), .Ro(14), .SW(4), .CNTW(16), .HOLD(HOLD)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .lim_i(lim_i), .clr_i(clr_i),
    .in_i(in_i), .out_o(out_o), .pos_sat_o(pos_sat_o), .neg_sat_o(neg_sat_o),
    .pos_sticky_o(pos_sticky_o), .neg_sticky_o(neg_sticky_o),
    .sat_events_o(sat_events_o), .railed_o(railed_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_out = 0; m_pos = 0; m_neg = 0; m_ps = 0; m_ns = 0;
    m_ev = 0; m_run = 0; m_railed = 0;
  endtask

  task automatic model_step(input int en, input int lim, input int clr, input int x);
    int l, hi, lo, np, nn, v, onset;
    if (en != 0) begin
      l  = (lim > 13) ? 13 : lim;
      hi = (1 << l) - 1;
      lo = -(1 << l);
      np = 0; nn = 0; v = x;
      if (x > hi) begin v = hi; np = 1; end
      else if (x < lo) begin v = lo; nn = 1; end
      onset = ((np == 1 && m_pos == 0) || (nn == 1 && m_neg == 0)) ? 1 : 0;
      if (clr != 0) m_ev = onset;
      else if (onset == 1 && m_ev < CNT_MAX) m_ev = m_ev + 1;
      if (np == 0 && nn == 0) m_run = 0;
      else if (clr != 0 || onset == 1) m_run = 1;
      else if (m_run < CNT_MAX) m_run = m_run + 1;
      m_ps = (np == 1) ? 1 : ((clr != 0) ? 0 : m_ps);
      m_ns = (nn == 1) ? 1 : ((clr != 0) ? 0 : m_ns);
      m_out = v; m_pos = np; m_neg = nn;
      m_railed = (m_run >= HOLD) ? 1 : 0;
    end else if (clr != 0) begin
      m_ps = 0; m_ns = 0; m_ev = 0; m_run = 0; m_railed = 0;
    end
  endtask

  task automatic check_all();
    chk("out",        int'(out_o),        m_out);
    chk("pos_sat",    int'(pos_sat_o),    m_pos);
    chk("neg_sat",    int'(neg_sat_o),    m_neg);
    chk("pos_sticky", int'(pos_sticky_o), m_ps);
    chk("neg_sticky", int'(neg_sticky_o), m_ns);
    chk("sat_events", int'(sat_events_o), m_ev);
    chk("railed",     int'(railed_o),     m_railed);
  endtask

  task automatic step(input int en, input int lim, input int clr, input int x);
    en_i  = (en != 0);
    lim_i = 4'(lim);
    clr_i = (clr != 0);
    in_i  = 15'(x);
    @(posedge clk_i);
    model_step(en, lim, clr, x);
    #1;
    check_all();
  endtask

  initial begin
    rst_i = 1'b1; en_i = 1'b0; lim_i = 4'd13; clr_i = 1'b0; in_i = '0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    check_all();
    @(negedge clk_i);
    rst_i = 1'b0;

    // clamp at full range
    step(1, 13, 0, 9000);  chk("full_hi", int'(out_o), 8191);  chk("full_hi_flag", int'(pos_sat_o), 1);
    step(1, 13, 0, -9000); chk("full_lo", int'(out_o), -8192); chk("full_lo_flag", int'(neg_sat_o), 1);
    step(1, 13, 0, -5);    chk("pass", int'(out_o), -5);       chk("pass_flags", int'(pos_sat_o | neg_sat_o), 0);

    // narrow limits, limit boundary, oversized limit code
    step(1, 4, 0, 15);     chk("l4_15", int'(out_o), 15);      chk("l4_15_flag", int'(pos_sat_o), 0);
    step(1, 4, 0, 16);     chk("l4_16", int'(out_o), 15);      chk("l4_16_flag", int'(pos_sat_o), 1);
    step(1, 4, 0, -20);    chk("l4_m20", int'(out_o), -16);    chk("l4_m20_flag", int'(neg_sat_o), 1);
    step(1, 0, 0, 1);      chk("l0_hi", int'(out_o), 0);
    step(1, 0, 0, -1);     chk("l0_m1", int'(out_o), -1);
    step(1, 15, 0, 9000);  chk("l15", int'(out_o), 8191);

    // event counting including a direction flip
    step(1, 13, 1, 0);     chk("ev_clr", int'(sat_events_o), 0);
    step(1, 13, 0, 0);
    step(1, 13, 0, 9000);
    step(1, 13, 0, 9000);
    step(1, 13, 0, 0);
    step(1, 13, 0, -9000); chk("ev_2", int'(sat_events_o), 2);
    step(1, 13, 0, 9000);  chk("ev_flip", int'(sat_events_o), 3);
    step(1, 13, 0, 0);
    step(1, 13, 1, 9000);  chk("ev_clr_onset", int'(sat_events_o), 1);
    chk("sticky_set_wins", int'(pos_sticky_o), 1);
    chk("sticky_neg_clr", int'(neg_sticky_o), 0);

    // railed after HOLD consecutive saturated samples
    step(1, 13, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 13, 0, 9000);
      chk("railed_seq", int'(railed_o), (i >= HOLD - 1) ? 1 : 0);
    end
    step(1, 13, 0, 0);     chk("railed_drop", int'(railed_o), 0);

    // enable gating and clr while disabled
    step(1, 13, 0, 9000);
    for (int i = 0; i < 10; i++) begin
      step(0, 13, 0, (i % 2 == 0) ? -9000 : 0);
      chk("hold_out", int'(out_o), 8191);
    end
    step(0, 13, 1, 9000);
    chk("clr_dis_ps", int'(pos_sticky_o), 0);
    chk("clr_dis_ev", int'(sat_events_o), 0);

    // async reset between edges while saturated
    step(1, 13, 0, 9000);
    step(1, 13, 0, 9000);
    #2 rst_i = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk_i);
    rst_i = 1'b0;
    step(1, 13, 0, 9000);  chk("post_rst_ev", int'(sat_events_o), 1);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      int x, en, clr, lim;
      case ($urandom_range(0, 3))
        0:       x = int'($urandom_range(0, 32767)) - 16384;
        1:       x = int'($urandom_range(0, 80)) - 40;
        2:       x = ($urandom_range(0, 1) == 1) ? 16383 : -16384;
        default: x = int'($urandom_range(0, 20000)) - 10000;
      endcase
      en  = ($urandom_range(0, 7) != 0) ? 1 : 0;
      clr = ($urandom_range(0, 15) == 0) ? 1 : 0;
      lim = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : 13;
      step(en, lim, clr, x);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
